// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU with valid/ready handshake on both sides.
// Single-cycle logic/arith ops plus iterative shift-add signed/unsigned multiply.
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic                 i_CLK,
    input  logic                 i_RSTn,
    input  logic [WIDTH-1:0]     i_arg0,
    input  logic [WIDTH-1:0]     i_arg1,
    input  logic [2:0]           i_oper,
    input  logic                 i_VALID,
    output logic                 o_READY,
    output logic [2*WIDTH+3:0]   o_Y,
    output logic                 o_VALID,
    input  logic                 i_READY
);

    localparam int YW = 2*WIDTH + 4;
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_POP  = 3'b011;
    localparam logic [2:0] OP_OR   = 3'b100;
    localparam logic [2:0] OP_XOR  = 3'b101;
    localparam logic [2:0] OP_SMUL = 3'b110;
    localparam logic [2:0] OP_UMUL = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t               state_q;
    logic [YW-1:0]        y_q;
    logic [CW-1:0]        cnt_q;
    logic [2*WIDTH-1:0]   acc_q;
    logic [2*WIDTH-1:0]   mcand_q;
    logic [WIDTH-1:0]     mplier_q;
    logic                 neg_q;
    logic                 smul_q;

    logic                 accept_s;
    logic                 mul_op_s;
    logic                 signed_op_s;
    logic [2*WIDTH-1:0]   acc_nxt_s;
    logic [2*WIDTH-1:0]   prod_s;

    function automatic logic [WIDTH-1:0] popcount(input logic [2*WIDTH-1:0] bits);
        logic [WIDTH-1:0] cnt;
        cnt = {WIDTH{1'b0}};
        for (int i = 0; i < 2*WIDTH; i++) begin
            cnt = cnt + {{(WIDTH-1){1'b0}}, bits[i]};
        end
        return cnt;
    endfunction

    // Unsigned magnitude; the most negative value maps to 2^(WIDTH-1), still exact in WIDTH bits.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x, input logic take_abs);
        logic [WIDTH-1:0] m;
        if (take_abs && x[WIDTH-1]) begin
            m = ~x + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            m = x;
        end
        return m;
    endfunction

    function automatic logic [YW-1:0] alu_word(input logic [2:0] op,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
        logic [WIDTH:0]   ext;
        logic [WIDTH-1:0] lo;
        logic             c;
        logic             v;
        ext = {(WIDTH+1){1'b0}};
        lo  = {WIDTH{1'b0}};
        c   = 1'b0;
        v   = 1'b0;
        case (op)
            OP_ADD: begin
                ext = {1'b0, a} + {1'b0, b};
                lo  = ext[WIDTH-1:0];
                c   = ext[WIDTH];
                v   = (a[WIDTH-1] == b[WIDTH-1]) && (lo[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                ext = {1'b0, a} - {1'b0, b};
                lo  = ext[WIDTH-1:0];
                c   = ext[WIDTH];
                v   = (a[WIDTH-1] != b[WIDTH-1]) && (lo[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  lo = a & b;
            OP_OR:   lo = a | b;
            OP_XOR:  lo = a ^ b;
            OP_POP:  lo = popcount({b, a});
            default: lo = {WIDTH{1'b0}};
        endcase
        return {{WIDTH{1'b0}}, lo, lo[WIDTH-1], (lo == {WIDTH{1'b0}}), c, v};
    endfunction

    function automatic logic [YW-1:0] mul_word(input logic [2*WIDTH-1:0] prod,
                                               input logic is_signed);
        logic [WIDTH-1:0] hi;
        logic [WIDTH-1:0] lo;
        logic             v;
        hi = prod[2*WIDTH-1:WIDTH];
        lo = prod[WIDTH-1:0];
        if (is_signed) begin
            v = (hi != {WIDTH{lo[WIDTH-1]}});
        end else begin
            v = (hi != {WIDTH{1'b0}});
        end
        return {hi, lo, hi[WIDTH-1], (prod == {(2*WIDTH){1'b0}}), 1'b0, v};
    endfunction

    // Ready depends on downstream only while a result is being held.
    always_comb begin
        o_READY = 1'b0;
        case (state_q)
            ST_IDLE: o_READY = 1'b1;
            ST_BUSY: o_READY = 1'b0;
            ST_HOLD: o_READY = i_READY;
            default: o_READY = 1'b0;
        endcase
    end

    assign accept_s    = i_VALID && o_READY;
    assign mul_op_s    = (i_oper == OP_SMUL) || (i_oper == OP_UMUL);
    assign signed_op_s = (i_oper == OP_SMUL);

    // One shift-add step and the sign-corrected product it would produce.
    always_comb begin
        acc_nxt_s = acc_q + (mplier_q[0] ? mcand_q : {(2*WIDTH){1'b0}});
        if (neg_q) begin
            prod_s = ~acc_nxt_s + {{(2*WIDTH-1){1'b0}}, 1'b1};
        end else begin
            prod_s = acc_nxt_s;
        end
    end

    // Control FSM, multiply datapath and result register.
    always_ff @(posedge i_CLK or negedge i_RSTn) begin
        if (!i_RSTn) begin
            state_q  <= ST_IDLE;
            y_q      <= {YW{1'b0}};
            cnt_q    <= {CW{1'b0}};
            acc_q    <= {(2*WIDTH){1'b0}};
            mcand_q  <= {(2*WIDTH){1'b0}};
            mplier_q <= {WIDTH{1'b0}};
            neg_q    <= 1'b0;
            smul_q   <= 1'b0;
        end else if (accept_s) begin
            if (mul_op_s) begin
                state_q  <= ST_BUSY;
                cnt_q    <= {CW{1'b0}};
                acc_q    <= {(2*WIDTH){1'b0}};
                mcand_q  <= {{WIDTH{1'b0}}, magnitude(i_arg0, signed_op_s)};
                mplier_q <= magnitude(i_arg1, signed_op_s);
                neg_q    <= signed_op_s && (i_arg0[WIDTH-1] ^ i_arg1[WIDTH-1]);
                smul_q   <= signed_op_s;
            end else begin
                state_q <= ST_HOLD;
                y_q     <= alu_word(i_oper, i_arg0, i_arg1);
            end
        end else begin
            case (state_q)
                ST_BUSY: begin
                    acc_q    <= acc_nxt_s;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    if (cnt_q == CNT_LAST) begin
                        y_q     <= mul_word(prod_s, smul_q);
                        state_q <= ST_HOLD;
                        cnt_q   <= {CW{1'b0}};
                    end else begin
                        cnt_q <= cnt_q + {{(CW-1){1'b0}}, 1'b1};
                    end
                end
                ST_HOLD: begin
                    if (i_READY) begin
                        state_q <= ST_IDLE;
                    end else begin
                        state_q <= ST_HOLD;
                    end
                end
                ST_IDLE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign o_Y     = y_q;
    assign o_VALID = (state_q == ST_HOLD);

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=8): directed vectors, random ops vs an
// arithmetic reference model, back-to-back, backpressure and mid-multiply reset.
module tb_alu_seq;

    localparam int W = 8;

    logic          i_CLK = 1'b0;
    logic          i_RSTn;
    logic [W-1:0]  i_arg0;
    logic [W-1:0]  i_arg1;
    logic [2:0]    i_oper;
    logic          i_VALID;
    logic          o_READY;
    logic [2*W+3:0] o_Y;
    logic          o_VALID;
    logic          i_READY;

    int n_chk = 0;
    int n_err = 0;

    alu_seq #(.WIDTH(W)) dut (
        .i_CLK   (i_CLK),
        .i_RSTn  (i_RSTn),
        .i_arg0  (i_arg0),
        .i_arg1  (i_arg1),
        .i_oper  (i_oper),
        .i_VALID (i_VALID),
        .o_READY (o_READY),
        .o_Y     (o_Y),
        .o_VALID (o_VALID),
        .i_READY (i_READY)
    );

    always #5 i_CLK = ~i_CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference result {hi, lo, N, Z, C, V} from integer arithmetic.
    function automatic logic [19:0] model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        int ua, ub, sa, sb, r;
        logic [15:0] p;
        logic n, z, c, v, mul;
        ua = int'(a);
        ub = int'(b);
        sa = (ua >= 128) ? ua - 256 : ua;
        sb = (ub >= 128) ? ub - 256 : ub;
        r = 0; p = 16'h0000; c = 1'b0; v = 1'b0; mul = 1'b0;
        case (op)
            3'd0: begin r = ua + ub; p = 16'(r % 256); c = (r > 255); v = (sa + sb > 127) || (sa + sb < -128); end
            3'd1: begin r = ua - ub; p = 16'((r + 256) % 256); c = (ua < ub); v = (sa - sb > 127) || (sa - sb < -128); end
            3'd2: p = {8'h00, a & b};
            3'd3: p = 16'($countones({b, a}));
            3'd4: p = {8'h00, a | b};
            3'd5: p = {8'h00, a ^ b};
            3'd6: begin r = sa * sb; p = 16'(r); mul = 1'b1; v = (r > 127) || (r < -128); end
            3'd7: begin r = ua * ub; p = 16'(r); mul = 1'b1; v = (r > 255); end
            default: p = 16'h0000;
        endcase
        n = mul ? p[15] : p[7];
        z = mul ? (p == 16'h0000) : (p[7:0] == 8'h00);
        return {p, n, z, c, v};
    endfunction

    // Issue one op, scramble inputs after acceptance, check latency, ready and result.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [7:0] a,
                          input logic [7:0] b, input logic [19:0] exp);
        int lat;
        int guard;
        guard = 0;
        while (!o_READY && guard < 20) begin
            @(posedge i_CLK); #1;
            guard++;
        end
        chk({tag, "_rdy"}, 32'(o_READY), 32'd1);
        i_oper = op; i_arg0 = a; i_arg1 = b; i_VALID = 1'b1;
        @(posedge i_CLK); #1;
        i_VALID = 1'b0;
        i_arg0 = 8'($urandom);
        i_arg1 = 8'($urandom);
        i_oper = 3'($urandom);
        lat = 0;
        while (!o_VALID && lat < 20) begin
            chk({tag, "_busy_rdy"}, 32'(o_READY), 32'd0);
            @(posedge i_CLK); #1;
            lat++;
        end
        chk({tag, "_lat"}, 32'(lat), (op[2:1] == 2'b11) ? 32'd8 : 32'd0);
        chk({tag, "_y"}, 32'(o_Y), 32'(exp));
    endtask

    logic [19:0] expq[$];
    logic [19:0] held;
    logic [19:0] bp_exp;
    logic [7:0]  ra, rb;
    logic [2:0]  rop;

    initial begin
        i_RSTn = 1'b1; i_VALID = 1'b0; i_READY = 1'b1;
        i_arg0 = 8'h00; i_arg1 = 8'h00; i_oper = 3'b000;
        #2 i_RSTn = 1'b0;
        #2;
        chk("rst_valid", 32'(o_VALID), 32'd0);
        chk("rst_y", 32'(o_Y), 32'd0);
        repeat (2) @(posedge i_CLK);
        @(negedge i_CLK) i_RSTn = 1'b1;
        @(posedge i_CLK); #1;
        chk("rst_rdy", 32'(o_READY), 32'd1);
        chk("rst_valid2", 32'(o_VALID), 32'd0);

        run_op("add_ovf",  3'd0, 8'h7F, 8'h01, 20'h00809);
        run_op("sub_brw",  3'd1, 8'h00, 8'h01, 20'h00FFA);
        run_op("popcnt",   3'd3, 8'hFF, 8'h0F, 20'h000C0);
        run_op("and_zero", 3'd2, 8'hF0, 8'h0F, 20'h00004);
        run_op("smul_min", 3'd6, 8'h80, 8'h80, 20'h40001);
        run_op("smul_neg", 3'd6, 8'hFD, 8'h05, 20'hFFF18);
        run_op("umul_max", 3'd7, 8'hFF, 8'hFF, 20'hFE019);

        for (int k = 0; k < 40; k++) begin
            rop = 3'($urandom_range(0, 7));
            ra = 8'($urandom);
            rb = 8'($urandom);
            run_op("rnd", rop, ra, rb, model(rop, ra, rb));
        end

        for (int k = 0; k < 10; k++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            chk("b2b_rdy", 32'(o_READY), 32'd1);
            i_oper = 3'd0; i_arg0 = ra; i_arg1 = rb; i_VALID = 1'b1;
            expq.push_back(model(3'd0, ra, rb));
            @(posedge i_CLK); #1;
            chk("b2b_valid", 32'(o_VALID), 32'd1);
            chk("b2b_y", 32'(o_Y), 32'(expq.pop_front()));
        end
        i_VALID = 1'b0;
        held = model(3'd0, ra, rb);

        i_READY = 1'b0;
        ra = 8'($urandom);
        rb = 8'($urandom);
        i_oper = 3'd1; i_arg0 = ra; i_arg1 = rb; i_VALID = 1'b1;
        bp_exp = model(3'd1, ra, rb);
        for (int k = 0; k < 5; k++) begin
            @(posedge i_CLK); #1;
            chk("bp_y", 32'(o_Y), 32'(held));
            chk("bp_valid", 32'(o_VALID), 32'd1);
            chk("bp_rdy", 32'(o_READY), 32'd0);
        end
        i_READY = 1'b1;
        #1;
        chk("bp_rel_rdy", 32'(o_READY), 32'd1);
        @(posedge i_CLK); #1;
        i_VALID = 1'b0;
        chk("bp_new_valid", 32'(o_VALID), 32'd1);
        chk("bp_new_y", 32'(o_Y), 32'(bp_exp));

        i_oper = 3'd7; i_arg0 = 8'hC3; i_arg1 = 8'h5A; i_VALID = 1'b1;
        @(posedge i_CLK); #1;
        i_VALID = 1'b0;
        repeat (4) @(posedge i_CLK);
        #1;
        chk("mid_busy", 32'(o_READY), 32'd0);
        i_RSTn = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(o_VALID), 32'd0);
        chk("mid_rst_y", 32'(o_Y), 32'd0);
        @(negedge i_CLK) i_RSTn = 1'b1;
        repeat (10) @(posedge i_CLK);
        #1;
        chk("discard_valid", 32'(o_VALID), 32'd0);
        chk("discard_rdy", 32'(o_READY), 32'd1);
        run_op("post_rst", 3'd0, 8'h02, 8'h03, 20'h00050);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
